// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold handling
// and a saturating count of load-use bubbles.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic             id_alu_op,
  input  logic             id_reg_write_en,
  input  logic             id_alu_src,
  input  logic             id_mem_to_reg_en,
  input  logic             id_mem_read_en,
  input  logic             id_mem_write_en,
  input  logic             id_jumpl_en,
  input  logic             id_branch_en,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7_5,
  input  logic             ex_flush,
  input  logic             ex_hold,
  output logic             ex_valid,
  output logic             ex_alu_op,
  output logic             ex_reg_write_en,
  output logic             ex_alu_src,
  output logic             ex_mem_to_reg_en,
  output logic             ex_mem_read_en,
  output logic             ex_mem_write_en,
  output logic             ex_jumpl_en,
  output logic             ex_branch_en,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [RA_W-1:0]  ex_rs1,
  output logic [RA_W-1:0]  ex_rs2,
  output logic [RA_W-1:0]  ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7_5,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic            valid;
    logic            alu_op;
    logic            reg_write;
    logic            alu_src;
    logic            mem_to_reg;
    logic            mem_read;
    logic            mem_write;
    logic            jumpl;
    logic            branch;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [2:0]      funct3;
    logic            funct7_5;
  } idex_t;

  idex_t            ex_q, ex_d, id_word;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             uses_rs1, uses_rs2, hazard;

  assign uses_rs1 = (id_opcode != OP_JAL);
  assign uses_rs2 = (id_opcode == OP_RTYPE) || (id_opcode == OP_STORE) ||
                    (id_opcode == OP_BRANCH);

  assign hazard = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                  ((uses_rs1 && (ex_q.rd == id_rs1)) || (uses_rs2 && (ex_q.rd == id_rs2)));
  assign load_use_stall = hazard && !reset;

  // Control enables are qualified by id_valid so an invalid slot never carries live enables.
  always_comb begin
    id_word            = '0;
    id_word.valid      = id_valid;
    id_word.alu_op     = id_alu_op        & id_valid;
    id_word.reg_write  = id_reg_write_en  & id_valid;
    id_word.alu_src    = id_alu_src       & id_valid;
    id_word.mem_to_reg = id_mem_to_reg_en & id_valid;
    id_word.mem_read   = id_mem_read_en   & id_valid;
    id_word.mem_write  = id_mem_write_en  & id_valid;
    id_word.jumpl      = id_jumpl_en      & id_valid;
    id_word.branch     = id_branch_en     & id_valid;
    id_word.pc         = id_pc;
    id_word.rs1_data   = id_rs1_data;
    id_word.rs2_data   = id_rs2_data;
    id_word.imm        = id_imm;
    id_word.rs1        = id_rs1;
    id_word.rs2        = id_rs2;
    id_word.rd         = id_rd;
    id_word.funct3     = id_funct3;
    id_word.funct7_5   = id_funct7_5;
  end

  // Flush beats hold beats stall; only stall-inserted bubbles are counted.
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (ex_flush) begin
      ex_d = '0;
    end else if (ex_hold) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d = '0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      ex_d = id_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid         = ex_q.valid;
  assign ex_alu_op        = ex_q.alu_op;
  assign ex_reg_write_en  = ex_q.reg_write;
  assign ex_alu_src       = ex_q.alu_src;
  assign ex_mem_to_reg_en = ex_q.mem_to_reg;
  assign ex_mem_read_en   = ex_q.mem_read;
  assign ex_mem_write_en  = ex_q.mem_write;
  assign ex_jumpl_en      = ex_q.jumpl;
  assign ex_branch_en     = ex_q.branch;
  assign ex_pc            = ex_q.pc;
  assign ex_rs1_data      = ex_q.rs1_data;
  assign ex_rs2_data      = ex_q.rs2_data;
  assign ex_imm           = ex_q.imm;
  assign ex_rs1           = ex_q.rs1;
  assign ex_rs2           = ex_q.rs2;
  assign ex_rd            = ex_q.rd;
  assign ex_funct3        = ex_q.funct3;
  assign ex_funct7_5      = ex_q.funct7_5;
  assign bubble_count     = cnt_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between instruction decode and execute in the 5-stage RISC-V core.
- Captures the control enables, operands, immediate and register addresses produced in ID and presents them to EX one cycle later.
- Owns load-use hazard detection: it stalls PC/IF-ID and inserts a bubble.
- Handles branch/jump flush from EX and hold from downstream, and keeps a saturating bubble counter for debug.

Parameters:
XLEN, 32, operand/immediate/PC width
RA_W, 5, register address width
CNT_W, 16, bubble counter width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_opcode  in  7  instruction opcode, used for hazard operand-usage
id_alu_op, id_reg_write_en, id_alu_src, id_mem_to_reg_en, id_mem_read_en, id_mem_write_en, id_jumpl_en, id_branch_en  in  1 each  decoder control enables
id_pc  in  XLEN  instruction PC
id_rs1_data, id_rs2_data  in  XLEN  register file read data
id_imm  in  XLEN  sign-extended immediate
id_rs1, id_rs2, id_rd  in  RA_W  register addresses
id_funct3  in  3  funct3 field
id_funct7_5  in  1  instruction bit 30
ex_flush  in  1  branch/jump taken in EX; kill ID/EX contents
ex_hold  in  1  EX/MEM cannot accept; freeze ID/EX
ex_valid  out  1  EX holds a real instruction
ex_alu_op, ex_reg_write_en, ex_alu_src, ex_mem_to_reg_en, ex_mem_read_en, ex_mem_write_en, ex_jumpl_en, ex_branch_en  out  1 each  registered enables
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered data
ex_rs1, ex_rs2, ex_rd  out  RA_W  registered addresses
ex_funct3  out  3  registered funct3
ex_funct7_5  out  1  registered bit 30
load_use_stall  out  1  combinational; freeze PC and IF/ID this cycle
bubble_count  out  CNT_W  bubbles inserted since reset, saturating

Behaviour:
- Reset: every ex_* output, including ex_valid, is 0. bubble_count is 0. While reset is high, load_use_stall is 0.
- Latency: 1 cycle, ID at edge N appears on ex_* after edge N.
- Operand usage:
  - uses_rs1 = 1 for every opcode except 1101111 (JAL).
  - uses_rs2 = 1 only for 0110011, 0100011 and 1100011.
- load_use_stall = id_valid & ex_valid & ex_mem_read_en & (ex_rd != 0) & ((uses_rs1 & ex_rd == id_rs1) | (uses_rs2 & ex_rd == id_rs2)).
- Per-edge update priority:
  1. reset: clear all.
  2. ex_flush: load a bubble, no count.
  3. ex_hold: all ex_* registers keep their values. load_use_stall is still evaluated, so ID also freezes.
  4. load_use_stall: load a bubble and increment bubble_count.
  5. Otherwise load ID: ex_valid <= id_valid. Data and address fields load as-is; control enables load AND id_valid.
- Bubble means:
  - ex_valid and all eight enables are 0.
  - All data/address/funct fields are 0 (deterministic, eases waveform checks).
- Invariant: ex_valid = 0 implies all ex enables = 0.
- A flush and a load_use_stall in the same cycle: the flush wins, the bubble is not counted, and the load_use_stall output is still driven as computed.
- A load_use_stall lasts exactly one cycle per hazard: after the bubble, ex_mem_read_en = 0 and the stall drops.
- bubble_count stops at all-ones and does not wrap.
- Reset asserted mid-hold or mid-stall: the next edge clears everything and prior state is discarded.

Test Plan:
- Reset, then id_valid=1, opcode 0110011, rd=3, rs1_data=0x11, rs2_data=0x22, reg_write=alu_op=1 -> after one edge ex_valid=1, ex_rd=3, ex_rs1_data=0x11, ex_reg_write_en=1. With reset high, all ex_* are 0.
- Load rd=5 (opcode 0000011) followed by R-type rs2=5 -> load_use_stall=1 for exactly one cycle, a bubble enters EX (all zeros), bubble_count=1, then the R-type enters on the next edge. Repeating with rd=0 -> no stall.
- Load rd=5 followed by JAL (opcode 1101111) whose rs1 field is 5 -> no stall. Followed by I-type with rs2 field 5 -> no stall.
- ex_hold=1 for 3 cycles with a valid ADD in EX and new values on ID -> ex_* unchanged for 3 cycles, then the ID values load after ex_hold drops.
- ex_flush=1 coincident with ex_hold=1 and a load-use hazard -> next edge ex_valid=0, all fields 0, and bubble_count unchanged.
- Force 2^CNT_W+2 hazards (or CNT_W=2 with 5 hazards) -> bubble_count saturates at all-ones. Reset mid-sequence -> 0.
